// File: rtl/debounce_pkg.sv
// Shared types and constants for the multi-channel debouncer.
package debounce_pkg;

   typedef enum logic {IDLE, COUNTING} debounce_state_t;

   localparam int unsigned GLITCH_COUNT_WIDTH = 8;

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: synchroniser, threshold counter FSM, edge pulses and, when
// DEBOUNCE_MULTI_GLITCH_COUNT_EN is defined, a saturating tally of aborted counts.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int unsigned CounterWidth = 16,
   parameter int unsigned SyncStages   = 2
) (
   input  logic                          clock_i,
   input  logic                          reset_i,
   input  logic [CounterWidth-1:0]       threshold_i,
   input  logic                          bouncing_i,
   output logic                          debounced_o,
   output logic                          rise_o,
   output logic                          fall_o,
   output logic [GLITCH_COUNT_WIDTH-1:0] glitch_count_o
);

   logic [SyncStages-1:0]   sync_q;
   logic                    sample;
   logic [CounterWidth-1:0] teff;
   logic [CounterWidth-1:0] thr_q;
   logic [CounterWidth-1:0] cnt_q;
   logic                    out_q;
   logic                    rise_q;
   logic                    fall_q;
   debounce_state_t         state_q;

   assign sample = sync_q[SyncStages-1];
   // A zero threshold behaves like one: commit on the first differing sample.
   assign teff   = (threshold_i == '0) ? CounterWidth'(1) : threshold_i;

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SyncStages-2:0], bouncing_i};
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         thr_q   <= '0;
         out_q   <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (sample != out_q) begin
                  thr_q <= teff;
                  if (teff == CounterWidth'(1)) begin
                     out_q  <= ~out_q;
                     rise_q <= ~out_q;
                     fall_q <= out_q;
                  end else begin
                     cnt_q   <= CounterWidth'(1);
                     state_q <= COUNTING;
                  end
               end
            end
            COUNTING: begin
               if (sample == out_q) begin
                  cnt_q   <= '0;
                  state_q <= IDLE;
               end else if (cnt_q + CounterWidth'(1) == thr_q) begin
                  out_q   <= ~out_q;
                  rise_q  <= ~out_q;
                  fall_q  <= out_q;
                  cnt_q   <= '0;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q + CounterWidth'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign debounced_o = out_q;
   assign rise_o      = rise_q;
   assign fall_o      = fall_q;

`ifdef DEBOUNCE_MULTI_GLITCH_COUNT_EN
   logic                          abort;
   logic [GLITCH_COUNT_WIDTH-1:0] glitch_q;

   assign abort = (state_q == COUNTING) && (sample == out_q);

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         glitch_q <= '0;
      end else if (abort && (glitch_q != '1)) begin
         glitch_q <= glitch_q + GLITCH_COUNT_WIDTH'(1);
      end
   end

   assign glitch_count_o = glitch_q;
`else
   assign glitch_count_o = '0;
`endif

endmodule

// File: rtl/debounce_multi.sv
// Bank of independent debounce channels sharing one runtime threshold.
// Per-channel glitch counters are built only with DEBOUNCE_MULTI_GLITCH_COUNT_EN.
module debounce_multi
   import debounce_pkg::*;
#(
   parameter int unsigned NUM_CHANNELS           = 4,
   parameter int unsigned DEBOUNCE_COUNTER_WIDTH = 16,
   parameter int unsigned SYNC_STAGES            = 2
) (
   input  logic                                       i_clock,
   input  logic                                       i_reset,
   input  logic [DEBOUNCE_COUNTER_WIDTH-1:0]          i_debounce_counter,
   input  logic [NUM_CHANNELS-1:0]                    i_bouncing_signal,
   output logic [NUM_CHANNELS-1:0]                    o_debounced_signal,
   output logic [NUM_CHANNELS-1:0]                    o_rise_pulse,
   output logic [NUM_CHANNELS-1:0]                    o_fall_pulse,
   output logic [NUM_CHANNELS*GLITCH_COUNT_WIDTH-1:0] o_glitch_count
);

   for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
      debounce_channel #(
         .CounterWidth (DEBOUNCE_COUNTER_WIDTH),
         .SyncStages   (SYNC_STAGES)
      ) u_channel (
         .clock_i        (i_clock),
         .reset_i        (i_reset),
         .threshold_i    (i_debounce_counter),
         .bouncing_i     (i_bouncing_signal[i]),
         .debounced_o    (o_debounced_signal[i]),
         .rise_o         (o_rise_pulse[i]),
         .fall_o         (o_fall_pulse[i]),
         .glitch_count_o (o_glitch_count[GLITCH_COUNT_WIDTH*i +: GLITCH_COUNT_WIDTH])
      );
   end

endmodule
